// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32I core: trap-side and pipeline CSR access,
// mstatus trap/MRET stacking, and the 64-bit cycle/instret counters.
module csr_file #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  trap_status,
  input  logic [11:0] csr_trap_address,
  input  logic [31:0] csr_trap_write_data,
  input  logic [11:0] csr_read_address,
  input  logic        csr_write_enable,
  input  logic [11:0] csr_write_address,
  input  logic [31:0] csr_write_data,
  input  logic        instret_inc,
  output logic [31:0] csr_read_data,
  output logic        csr_illegal
);

  localparam logic [2:0] TRAP_NONE       = 3'd0;
  localparam logic [2:0] TRAP_EBREAK     = 3'd1;
  localparam logic [2:0] TRAP_ECALL      = 3'd2;
  localparam logic [2:0] TRAP_MISALIGNED = 3'd3;
  localparam logic [2:0] TRAP_FENCEI     = 3'd4;
  localparam logic [2:0] TRAP_MRET       = 3'd5;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  function automatic logic is_implemented(input logic [11:0] addr);
    case (addr)
      ADDR_MSTATUS, ADDR_MISA, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC,
      ADDR_MCAUSE, ADDR_MTVAL, ADDR_MCYCLE, ADDR_MINSTRET, ADDR_MCYCLEH,
      ADDR_MINSTRETH, ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID,
      ADDR_MHARTID: is_implemented = 1'b1;
      default:      is_implemented = 1'b0;
    endcase
  endfunction

  function automatic logic is_read_only(input logic [11:0] addr);
    case (addr)
      ADDR_MISA, ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID,
      ADDR_MHARTID: is_read_only = 1'b1;
      default:      is_read_only = 1'b0;
    endcase
  endfunction

  // mtvec and mepc keep only [31:2]; their low bits always read as zero
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [29:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [29:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
  logic [2:0]  prev_trap_q, prev_trap_d;

  logic        trap_side_select;
  logic        trap_write_kind;
  logic        trap_write;
  logic        mret_first;
  logic        pipe_write;
  logic [11:0] read_address;
  logic [31:0] mstatus_value;

  assign mstatus_value = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};

  always_comb begin
    trap_side_select = (trap_status == TRAP_EBREAK) || (trap_status == TRAP_ECALL) ||
                       (trap_status == TRAP_MISALIGNED) || (trap_status == TRAP_MRET);
    trap_write_kind  = (trap_status == TRAP_EBREAK) || (trap_status == TRAP_ECALL) ||
                       (trap_status == TRAP_MISALIGNED);
    trap_write       = trap_write_kind &&
                       ((csr_trap_address == ADDR_MEPC) || (csr_trap_address == ADDR_MCAUSE) ||
                        (csr_trap_address == ADDR_MTVAL));
    mret_first       = (trap_status == TRAP_MRET) && (prev_trap_q != TRAP_MRET);
    // A trap-side update means the pipeline is being flushed, so its write is discarded
    pipe_write       = csr_write_enable && is_implemented(csr_write_address) &&
                       !is_read_only(csr_write_address) && !trap_write && !mret_first;
  end

  always_comb begin
    read_address  = trap_side_select ? csr_trap_address : csr_read_address;
    csr_read_data = 32'd0;
    case (read_address)
      ADDR_MSTATUS:   csr_read_data = mstatus_value;
      ADDR_MISA:      csr_read_data = MISA_VALUE;
      ADDR_MTVEC:     csr_read_data = {mtvec_q, 2'b00};
      ADDR_MSCRATCH:  csr_read_data = mscratch_q;
      ADDR_MEPC:      csr_read_data = {mepc_q, 2'b00};
      ADDR_MCAUSE:    csr_read_data = mcause_q;
      ADDR_MTVAL:     csr_read_data = mtval_q;
      ADDR_MCYCLE:    csr_read_data = mcycle_q[31:0];
      ADDR_MINSTRET:  csr_read_data = minstret_q[31:0];
      ADDR_MCYCLEH:   csr_read_data = mcycle_q[63:32];
      ADDR_MINSTRETH: csr_read_data = minstret_q[63:32];
      ADDR_MHARTID:   csr_read_data = HART_ID;
      default:        csr_read_data = 32'd0;
    endcase
  end

  assign csr_illegal = !is_implemented(csr_read_address) ||
                       (csr_write_enable && (is_read_only(csr_write_address) ||
                                             !is_implemented(csr_write_address)));

  always_comb begin
    mie_d       = mie_q;
    mpie_d      = mpie_q;
    mtvec_d     = mtvec_q;
    mscratch_d  = mscratch_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    mtval_d     = mtval_q;
    mcycle_d    = mcycle_q + 64'd1;
    minstret_d  = minstret_q + {63'd0, instret_inc};
    prev_trap_d = trap_status;

    if (pipe_write) begin
      case (csr_write_address)
        ADDR_MSTATUS: begin
          mie_d  = csr_write_data[3];
          mpie_d = csr_write_data[7];
        end
        ADDR_MTVEC:     mtvec_d    = csr_write_data[31:2];
        ADDR_MSCRATCH:  mscratch_d = csr_write_data;
        ADDR_MEPC:      mepc_d     = csr_write_data[31:2];
        ADDR_MCAUSE:    mcause_d   = csr_write_data;
        ADDR_MTVAL:     mtval_d    = csr_write_data;
        // Low-half writes suppress the increment; high-half writes leave the low half counting without carry
        ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], csr_write_data};
        ADDR_MCYCLEH:   mcycle_d   = {csr_write_data, mcycle_q[31:0] + 32'd1};
        ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], csr_write_data};
        ADDR_MINSTRETH: minstret_d = {csr_write_data, minstret_q[31:0] + {31'd0, instret_inc}};
        default: ;
      endcase
    end

    if (trap_write) begin
      case (csr_trap_address)
        ADDR_MEPC: mepc_d = csr_trap_write_data[31:2];
        ADDR_MCAUSE: begin
          mcause_d = csr_trap_write_data;
          mpie_d   = mie_q;
          mie_d    = 1'b0;
        end
        ADDR_MTVAL: mtval_d = csr_trap_write_data;
        default: ;
      endcase
    end

    if (mret_first) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q       <= 1'b0;
      mpie_q      <= 1'b0;
      mtvec_q     <= MTVEC_RESET[31:2];
      mscratch_q  <= 32'd0;
      mepc_q      <= 30'd0;
      mcause_q    <= 32'd0;
      mtval_q     <= 32'd0;
      mcycle_q    <= 64'd0;
      minstret_q  <= 64'd0;
      prev_trap_q <= TRAP_NONE;
    end else begin
      mie_q       <= mie_d;
      mpie_q      <= mpie_d;
      mtvec_q     <= mtvec_d;
      mscratch_q  <= mscratch_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      mtval_q     <= mtval_d;
      mcycle_q    <= mcycle_d;
      minstret_q  <= minstret_d;
      prev_trap_q <= prev_trap_d;
    end
  end

  // FENCEI and NONE are decoded only implicitly (neither selects nor writes)
  logic unused_codes;
  assign unused_codes = (TRAP_FENCEI == TRAP_NONE);

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed vector table, counter/reset
// sequences, and random traffic against a behavioural model.
module tb_csr_file;

  localparam logic [31:0] P_HART  = 32'd3;
  localparam logic [31:0] P_MTVEC = 32'h0000_1003;
  localparam logic [31:0] P_MISA  = 32'h4000_0100;

  localparam logic [2:0] T_NONE = 3'd0, T_EBREAK = 3'd1, T_ECALL = 3'd2,
                         T_MISAL = 3'd3, T_FENCEI = 3'd4, T_MRET = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  trap_status;
  logic [11:0] csr_trap_address;
  logic [31:0] csr_trap_write_data;
  logic [11:0] csr_read_address;
  logic        csr_write_enable;
  logic [11:0] csr_write_address;
  logic [31:0] csr_write_data;
  logic        instret_inc;
  logic [31:0] csr_read_data;
  logic        csr_illegal;

  csr_file #(.HART_ID(P_HART), .MTVEC_RESET(P_MTVEC), .MISA_VALUE(P_MISA)) dut (
    .clk(clk), .rst_n(rst_n), .trap_status(trap_status),
    .csr_trap_address(csr_trap_address), .csr_trap_write_data(csr_trap_write_data),
    .csr_read_address(csr_read_address), .csr_write_enable(csr_write_enable),
    .csr_write_address(csr_write_address), .csr_write_data(csr_write_data),
    .instret_inc(instret_inc), .csr_read_data(csr_read_data), .csr_illegal(csr_illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- behavioural reference model ----------------
  bit          m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;
  logic [2:0]  m_prev;

  function automatic bit m_impl(input logic [11:0] a);
    return a inside {12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                     12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF11, 12'hF12, 12'hF13, 12'hF14};
  endfunction

  function automatic bit m_ro(input logic [11:0] a);
    return a inside {12'h301, 12'hF11, 12'hF12, 12'hF13, 12'hF14};
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
      12'h301: return P_MISA;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hB00: return m_cycle[31:0];
      12'hB02: return m_instret[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB82: return m_instret[63:32];
      12'hF14: return P_HART;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0;
    m_mtvec = P_MTVEC & ~32'h3;
    m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_cycle = 0; m_instret = 0; m_prev = T_NONE;
  endtask

  task automatic model_step();
    bit tw, mr, nmie, nmpie;
    logic [63:0] nc, ni;
    tw = (trap_status inside {T_EBREAK, T_ECALL, T_MISAL}) &&
         (csr_trap_address inside {12'h341, 12'h342, 12'h343});
    mr = (trap_status == T_MRET) && (m_prev != T_MRET);
    nc = m_cycle + 1;
    ni = m_instret + (instret_inc ? 64'd1 : 64'd0);
    nmie = m_mie; nmpie = m_mpie;
    if (csr_write_enable && m_impl(csr_write_address) && !m_ro(csr_write_address) && !tw && !mr) begin
      case (csr_write_address)
        12'h300: begin nmie = csr_write_data[3]; nmpie = csr_write_data[7]; end
        12'h305: m_mtvec = csr_write_data & ~32'h3;
        12'h340: m_mscratch = csr_write_data;
        12'h341: m_mepc = csr_write_data & ~32'h3;
        12'h342: m_mcause = csr_write_data;
        12'h343: m_mtval = csr_write_data;
        12'hB00: nc = (m_cycle & 64'hFFFF_FFFF_0000_0000) | 64'(csr_write_data);
        12'hB80: nc = (64'(csr_write_data) << 32) | ((m_cycle + 1) & 64'hFFFF_FFFF);
        12'hB02: ni = (m_instret & 64'hFFFF_FFFF_0000_0000) | 64'(csr_write_data);
        12'hB82: ni = (64'(csr_write_data) << 32) |
                      ((m_instret + (instret_inc ? 64'd1 : 64'd0)) & 64'hFFFF_FFFF);
        default: ;
      endcase
    end
    if (tw) begin
      case (csr_trap_address)
        12'h341: m_mepc = csr_trap_write_data & ~32'h3;
        12'h342: begin m_mcause = csr_trap_write_data; nmpie = m_mie; nmie = 0; end
        default: m_mtval = csr_trap_write_data;
      endcase
    end
    if (mr) begin nmie = m_mpie; nmpie = 1; end
    m_mie = nmie; m_mpie = nmpie;
    m_cycle = nc; m_instret = ni;
    m_prev = trap_status;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
  endtask

  task automatic apply(input logic [2:0] tr, input logic [11:0] ta, input logic [31:0] td,
                       input logic [11:0] ra, input logic we, input logic [11:0] wa,
                       input logic [31:0] wd, input logic inc);
    trap_status = tr; csr_trap_address = ta; csr_trap_write_data = td;
    csr_read_address = ra; csr_write_enable = we; csr_write_address = wa;
    csr_write_data = wd; instret_inc = inc;
  endtask

  task automatic check_read(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_read_address = a;
    #1;
    chk(name, 0, csr_read_data, exp);
  endtask

  typedef struct {
    logic [2:0]  tr;
    logic [11:0] ta;
    logic [31:0] td;
    logic [11:0] ra;
    logic        we;
    logic [11:0] wa;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_ill;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] tr, input logic [11:0] ta, input logic [31:0] td,
                              input logic [11:0] ra, input logic we, input logic [11:0] wa,
                              input logic [31:0] wd, input logic [31:0] er, input logic ei);
    vec_t v;
    v.tr = tr; v.ta = ta; v.td = td; v.ra = ra; v.we = we; v.wa = wa; v.wd = wd;
    v.exp_rd = er; v.exp_ill = ei;
    return v;
  endfunction

  function automatic logic [11:0] rand_addr();
    logic [11:0] pool [16];
    pool = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hB00,
             12'hB02, 12'hB80, 12'hB82, 12'hF11, 12'hF12, 12'hF14, 12'h7C0, 12'h000};
    if ($urandom_range(0, 9) == 0) return 12'($urandom);
    return pool[$urandom_range(0, 15)];
  endfunction

  vec_t vq[$];

  initial begin
    apply(T_NONE, 0, 0, 12'h300, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Reset: asserted asynchronously mid-cycle, values visible immediately
    #6 rst_n = 1'b0;
    model_reset();
    check_read("rst_mstatus", 12'h300, 32'h0000_1800);
    check_read("rst_mtvec", 12'h305, P_MTVEC & ~32'h3);
    check_read("rst_mhartid", 12'hF14, P_HART);
    tick();
    check_read("rst_mcycle", 12'hB00, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check_read("mcycle_first", 12'hB00, 32'h1);

    // Directed table: each row is one cycle; outputs checked before the edge
    vq.push_back(mk(T_NONE,  0, 0, 12'h300, 1, 12'h300, 32'h8, 32'h1800, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h300, 0, 0, 0, 32'h1808, 0));
    vq.push_back(mk(T_ECALL, 12'h341, 32'h80, 12'h300, 0, 0, 0, 32'h0, 0));
    vq.push_back(mk(T_ECALL, 12'h342, 32'd11, 12'h300, 0, 0, 0, 32'h0, 0));
    vq.push_back(mk(T_ECALL, 12'h305, 32'h0, 12'h300, 0, 0, 0, 32'h1000, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h341, 0, 0, 0, 32'h80, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h342, 0, 0, 0, 32'd11, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h300, 0, 0, 0, 32'h1880, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h305, 0, 0, 0, 32'h1000, 0));
    vq.push_back(mk(T_MRET,  12'h341, 0, 12'h300, 0, 0, 0, 32'h80, 0));
    vq.push_back(mk(T_MRET,  12'h300, 0, 12'h300, 0, 0, 0, 32'h1888, 0));
    vq.push_back(mk(T_MRET,  12'h300, 0, 12'h300, 0, 0, 0, 32'h1888, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h300, 0, 0, 0, 32'h1888, 0));
    vq.push_back(mk(T_MISAL, 12'h341, 32'h104, 12'h300, 1, 12'h340, 32'hDEAD, 32'h80, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h341, 0, 0, 0, 32'h104, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h340, 0, 0, 0, 32'h0, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h340, 1, 12'h340, 32'hDEAD, 32'h0, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h340, 0, 0, 0, 32'hDEAD, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h300, 1, 12'hF14, 32'h55, 32'h1888, 1));
    vq.push_back(mk(T_NONE,  0, 0, 12'hF14, 0, 0, 0, P_HART, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h340, 1, 12'h7C0, 32'h1, 32'hDEAD, 1));
    vq.push_back(mk(T_NONE,  0, 0, 12'h7C0, 0, 0, 0, 32'h0, 1));
    vq.push_back(mk(T_NONE,  0, 0, 12'h305, 1, 12'h305, 32'h2003, 32'h1000, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h305, 0, 0, 0, 32'h2000, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h301, 1, 12'h301, 32'h0, P_MISA, 1));
    vq.push_back(mk(T_NONE,  0, 0, 12'hF11, 0, 0, 0, 32'h0, 0));
    vq.push_back(mk(T_FENCEI, 12'h342, 32'h5, 12'h343, 1, 12'h343, 32'h77, 32'h0, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h343, 0, 0, 0, 32'h77, 0));
    vq.push_back(mk(T_EBREAK, 12'h000, 32'h99, 12'h300, 0, 0, 0, 32'h0, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h342, 0, 0, 0, 32'd11, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h300, 0, 0, 0, 32'h1888, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h341, 1, 12'h341, 32'h207, 32'h104, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h341, 0, 0, 0, 32'h204, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h300, 1, 12'h300, 32'hFFFF_FFF7, 32'h1888, 0));
    vq.push_back(mk(T_NONE,  0, 0, 12'h300, 0, 0, 0, 32'h1880, 0));

    foreach (vq[i]) begin
      apply(vq[i].tr, vq[i].ta, vq[i].td, vq[i].ra, vq[i].we, vq[i].wa, vq[i].wd, 0);
      #2;
      chk("vec_rd", i, csr_read_data, vq[i].exp_rd);
      chk("vec_ill", i, {31'd0, csr_illegal}, {31'd0, vq[i].exp_ill});
      tick();
    end

    // mcycle: high-half write, then low-half write to all-ones and carry
    apply(T_NONE, 0, 0, 12'hB80, 1, 12'hB80, 32'h1234, 0);
    tick();
    apply(T_NONE, 0, 0, 12'hB80, 1, 12'hB00, 32'hFFFF_FFFF, 0);
    #1 chk("mcycleh_wr", 0, csr_read_data, 32'h1234);
    tick();
    apply(T_NONE, 0, 0, 12'hB00, 0, 0, 0, 0);
    #1 chk("mcycle_wr", 0, csr_read_data, 32'hFFFF_FFFF);
    tick();
    check_read("mcycle_wrap", 12'hB00, 32'h0);
    tick();
    check_read("mcycle_after2", 12'hB00, 32'h1);
    check_read("mcycleh_carry", 12'hB80, 32'h1235);

    // minstret: five retiring cycles, low-half write on the third
    for (int k = 1; k <= 5; k++) begin
      apply(T_NONE, 0, 0, 12'hB02, (k == 3), 12'hB02, 32'h10, 1);
      tick();
    end
    apply(T_NONE, 0, 0, 12'hB02, 0, 0, 0, 0);
    check_read("minstret_final", 12'hB02, 32'h12);
    apply(T_NONE, 0, 0, 12'hB82, 1, 12'hB82, 32'hABCD, 1);
    tick();
    apply(T_NONE, 0, 0, 12'hB82, 0, 0, 0, 0);
    check_read("minstreth_wr", 12'hB82, 32'hABCD);
    check_read("minstret_inc_hi", 12'hB02, 32'h13);

    // Reset in the middle of a held MRET, then the detector re-arms
    apply(T_MRET, 12'h300, 0, 12'h300, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b0;
    model_reset();
    #1 chk("rst_mid_trap", 0, csr_read_data, 32'h1800);
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("mret_rearm", 0, csr_read_data, 32'h1880);
    tick();
    chk("mret_hold", 0, csr_read_data, 32'h1880);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [2:0] tr;
      tr = ($urandom_range(0, 1) == 0) ? T_NONE : 3'($urandom_range(0, 5));
      apply(tr, rand_addr(), $urandom, rand_addr(), 1'($urandom_range(0, 1)), rand_addr(),
            $urandom, 1'($urandom_range(0, 1)));
      #2;
      chk("rand_rd", i, csr_read_data,
          m_read((tr inside {T_EBREAK, T_ECALL, T_MISAL, T_MRET}) ? csr_trap_address : csr_read_address));
      chk("rand_ill", i, {31'd0, csr_illegal},
          {31'd0, !m_impl(csr_read_address) ||
                  (csr_write_enable && (m_ro(csr_write_address) || !m_impl(csr_write_address)))});
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
